bno085_spi_arbiter: RTL

- Shares the single SPI master engine, with its shared sclk/mosi/miso path, between two BNO085 sensor clients.
- Owns both chip selects. Grants the bus round-robin per transaction and routes byte-level start/done handshakes between the granted client and the master.
- Enforces CS setup/hold timing and recovers from a stalled client with a watchdog.
- Sits between the per-sensor controllers and the SPI master inside the drum trigger top.

---
 rtl/bno085_spi_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/bno085_spi_arbiter.sv
// bno085_spi_arbiter
// Shares one byte-oriented SPI master between two BNO085 sensor controllers.
// The arbiter owns both chip selects, grants the bus round-robin once per
// transaction, routes byte start/done handshakes between the owning client
// and the master, enforces chip-select setup/hold spacing and forcibly
// releases a client that stops talking (watchdog).
//
// Optional build macro: ARB_INT_PRIORITY_EN
//   When defined, an extra input int_n_i[1:0] (active-low sensor data-ready)
//   breaks a simultaneous-request tie in favour of the client whose sensor
//   is signalling data-ready. When undefined, arbitration is pure
//   round-robin and the port does not exist.
//
// Client 0 drives chip select bit 0 (sensor1), client 1 drives bit 1.

module bno085_spi_arbiter #(
  parameter int unsigned CS_SETUP       = 4,
  parameter int unsigned CS_HOLD        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  output logic [1:0]  grant_o,
  input  logic [15:0] tx_byte_i,
  input  logic [1:0]  start_i,
  output logic [1:0]  byte_done_o,
  output logic [7:0]  rx_byte_o,
  output logic        m_start_o,
  output logic [7:0]  m_tx_byte_o,
  input  logic        m_done_i,
  input  logic [7:0]  m_rx_byte_i,
`ifdef ARB_INT_PRIORITY_EN
  input  logic [1:0]  int_n_i,
`endif
  output logic [1:0]  cs_n_o,
  output logic        busy_o,
  output logic        timeout_err_o,
  output logic        err_sticky_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    GRANTED = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Terminal counts; each counter stops at its terminal value and the state
  // changes there, so neither counter can ever wrap.
  localparam logic [7:0]  SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [15:0] WDT_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [7:0]  cnt_q;
  logic [15:0] wdt_q;
  logic        in_flight_q;
  logic [1:0]  grant_q;
  logic [1:0]  cs_n_q;
  logic        m_start_q;
  logic [7:0]  m_tx_byte_q;
  logic [1:0]  byte_done_q;
  logic [7:0]  rx_byte_q;
  logic        busy_q;
  logic        timeout_err_q;
  logic        err_sticky_q;

  logic        pick_d;
  logic        owner_req;
  logic        owner_start;
  logic [7:0]  owner_tx;
  logic [1:0]  owner_onehot;
  logic        accept_start;
  logic        accept_done;

  // Arbitration choice for the IDLE cycle: a lone requester wins outright,
  // a tie goes to the client that did not own the bus last time (optionally
  // overridden by a single pending sensor data-ready).
  always_comb begin
    pick_d = 1'b0;
    if (req_i == 2'b11) begin
      pick_d = ~last_grant_q;
`ifdef ARB_INT_PRIORITY_EN
      if (int_n_i == 2'b10) begin
        pick_d = 1'b0;
      end else if (int_n_i == 2'b01) begin
        pick_d = 1'b1;
      end
`endif
    end else if (req_i[1]) begin
      pick_d = 1'b1;
    end
  end

  // Views of the current owner's request, start and transmit byte, plus the
  // byte-level handshake qualifiers used while GRANTED.
  always_comb begin
    owner_req    = req_i[owner_q];
    owner_start  = start_i[owner_q];
    owner_tx     = owner_q ? tx_byte_i[15:8] : tx_byte_i[7:0];
    owner_onehot = owner_q ? 2'b10 : 2'b01;
    accept_start = owner_start && !in_flight_q;
    accept_done  = m_done_i && in_flight_q;
  end

  // Arbiter FSM with all outputs registered; pulses default low every cycle.
  // Leaving a transaction always passes through HOLD, which raises both chip
  // selects, clears the in-flight byte and remembers the owner for
  // round-robin. HOLD lasts CS_HOLD cycles and is followed by one IDLE
  // arbitration cycle in which cs_n is also still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= 8'd0;
      wdt_q         <= 16'd0;
      in_flight_q   <= 1'b0;
      grant_q       <= 2'b00;
      cs_n_q        <= 2'b11;
      m_start_q     <= 1'b0;
      m_tx_byte_q   <= 8'd0;
      byte_done_q   <= 2'b00;
      rx_byte_q     <= 8'd0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      m_start_q     <= 1'b0;
      byte_done_q   <= 2'b00;
      timeout_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (|req_i) begin
            owner_q <= pick_d;
            cs_n_q  <= pick_d ? 2'b01 : 2'b10;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          if (!owner_req) begin
            state_q      <= HOLD;
            grant_q      <= 2'b00;
            cs_n_q       <= 2'b11;
            last_grant_q <= owner_q;
            in_flight_q  <= 1'b0;
            cnt_q        <= 8'd0;
          end else if (cnt_q == SETUP_LAST) begin
            state_q     <= GRANTED;
            grant_q     <= owner_onehot;
            wdt_q       <= 16'd0;
            in_flight_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        GRANTED: begin
          if (accept_start) begin
            m_tx_byte_q <= owner_tx;
            m_start_q   <= 1'b1;
            in_flight_q <= 1'b1;
            wdt_q       <= 16'd0;
          end else if (accept_done) begin
            rx_byte_q   <= m_rx_byte_i;
            byte_done_q <= owner_onehot;
            in_flight_q <= 1'b0;
            wdt_q       <= 16'd0;
          end else if (!owner_req && !in_flight_q) begin
            state_q      <= HOLD;
            grant_q      <= 2'b00;
            cs_n_q       <= 2'b11;
            last_grant_q <= owner_q;
            in_flight_q  <= 1'b0;
            cnt_q        <= 8'd0;
          end else if (m_done_i) begin
            wdt_q <= 16'd0;
          end else if (wdt_q == WDT_LAST) begin
            state_q       <= HOLD;
            grant_q       <= 2'b00;
            cs_n_q        <= 2'b11;
            last_grant_q  <= owner_q;
            in_flight_q   <= 1'b0;
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b1;
            err_sticky_q  <= 1'b1;
          end else begin
            wdt_q <= wdt_q + 16'd1;
          end
        end

        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          cs_n_q  <= 2'b11;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign cs_n_o        = cs_n_q;
  assign m_start_o     = m_start_q;
  assign m_tx_byte_o   = m_tx_byte_q;
  assign byte_done_o   = byte_done_q;
  assign rx_byte_o     = rx_byte_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;
  assign err_sticky_o  = err_sticky_q;

endmodule
